// File: rtl/wb_regfile.sv
// Write-back stage: selects load vs ALU data, commits it to the register file,
// and serves two combinational read ports with write-first bypass.
module wb_regfile #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              WBreg,
    input  logic              RegWritereg,
    input  logic [DATA_W-1:0] Memreg,
    input  logic [DATA_W-1:0] ALUreg,
    input  logic [ADDR_W-1:0] RegRDreg,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] wb_rd,
    output logic              wb_we,
    output logic [ADDR_W-1:0] last_rd,
    output logic [DATA_W-1:0] last_data,
    output logic              last_valid,
    output logic [15:0]       wr_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  entry_we;

    logic [ADDR_W-1:0] last_rd_q,    last_rd_d;
    logic [DATA_W-1:0] last_data_q,  last_data_d;
    logic              last_valid_q, last_valid_d;
    logic [15:0]       wr_count_q,   wr_count_d;

    assign wb_data = WBreg ? Memreg : ALUreg;
    assign wb_rd   = RegRDreg;
    assign wb_we   = RegWritereg & ~(R0_ZERO & (RegRDreg == '0));

    // Per-entry enables are qualified by wb_we so an unknown index with no write
    // pending can never reach the storage.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_we
        assign entry_we[gi] = wb_we && (RegRDreg == ADDR_W'(gi));
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_we[i]) begin
                    regs_q[i] <= wb_data;
                end
            end
        end
    end

    always_comb begin
        last_rd_d    = last_rd_q;
        last_data_d  = last_data_q;
        last_valid_d = last_valid_q;
        wr_count_d   = wr_count_q;
        if (wb_we) begin
            last_rd_d    = RegRDreg;
            last_data_d  = wb_data;
            last_valid_d = 1'b1;
            wr_count_d   = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            last_rd_q    <= '0;
            last_data_q  <= '0;
            last_valid_q <= 1'b0;
            wr_count_q   <= '0;
        end else begin
            last_rd_q    <= last_rd_d;
            last_data_q  <= last_data_d;
            last_valid_q <= last_valid_d;
            wr_count_q   <= wr_count_d;
        end
    end

    assign last_rd    = last_rd_q;
    assign last_data  = last_data_q;
    assign last_valid = last_valid_q;
    assign wr_count   = wr_count_q;

    // Read priority: hardwired zero, then the in-flight write, then storage.
    always_comb begin
        rs_data = regs_q[rs_addr];
        if (R0_ZERO && (rs_addr == '0)) begin
            rs_data = '0;
        end else if (wb_we && (rs_addr == RegRDreg)) begin
            rs_data = wb_data;
        end
    end

    always_comb begin
        rt_data = regs_q[rt_addr];
        if (R0_ZERO && (rt_addr == '0)) begin
            rt_data = '0;
        end else if (wb_we && (rt_addr == RegRDreg)) begin
            rt_data = wb_data;
        end
    end

endmodule
